// File: rtl/pll_phase_ctrl.sv
// Reset/lock sequencer and dynamic phase-step driver for an ECP5 EHXPLLL.
// Runs on the PLL reference clock and owns RST, PHASESEL, PHASEDIR and PHASESTEP.
module pll_phase_ctrl #(
  parameter int unsigned N_OUT          = 4,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned FILTER_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned STEP_LOW       = 4,
  parameter int unsigned STEP_GAP       = 8,
  parameter int unsigned STEP_W         = 8,
  parameter int unsigned PHASE_W        = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pll_lock,
  output logic                       pll_rst,
  output logic [1:0]                 pll_phasesel,
  output logic                       pll_phasedir,
  output logic                       pll_phasestep,
  output logic                       ready,
  output logic [7:0]                 relock_count,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_chan,
  input  logic                       req_dir,
  input  logic [STEP_W-1:0]          req_steps,
  output logic                       busy,
  output logic [N_OUT*PHASE_W-1:0]   phase_ofs
);

  localparam int unsigned MAX_A   = (RST_CYCLES > FILTER_CYCLES) ? RST_CYCLES : FILTER_CYCLES;
  localparam int unsigned MAX_B   = (STEP_LOW > STEP_GAP) ? STEP_LOW : STEP_GAP;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RESET, S_WAIT_LOCK, S_FILTER, S_READY, S_SETUP, S_PULSE, S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic                lock_meta, lock_sync;
  logic                lose_lock, ofs_step;

  logic                rst_d, ready_d, req_ready_d, busy_d, step_d, dir_d;
  logic [1:0]          sel_d;
  logic [7:0]          relock_d;
  logic [PHASE_W-1:0]  ofs_q [N_OUT];
  logic [PHASE_W-1:0]  ofs_d [N_OUT];

  // Two-flop synchroniser for the asynchronous LOCK pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      to_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    rem_d     = rem_q;
    lose_lock = 1'b0;
    ofs_step  = 1'b0;
    case (state_q)
      S_RESET: begin
        to_d = '0;
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        cnt_d = '0;
        if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_RESET;
          to_d    = '0;
        end else begin
          to_d = to_q + TO_W'(1);
          if (lock_sync) begin
            // The first synced-high cycle already counts toward the filter
            if (FILTER_CYCLES == 1) begin
              state_d = S_READY;
              to_d    = '0;
            end else begin
              state_d = S_FILTER;
              cnt_d   = CNT_W'(1);
            end
          end
        end
      end
      S_FILTER: begin
        if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_RESET;
          to_d    = '0;
          cnt_d   = '0;
        end else begin
          to_d = to_q + TO_W'(1);
          if (!lock_sync) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
            state_d = S_READY;
            cnt_d   = '0;
            to_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_READY: begin
        to_d  = '0;
        cnt_d = '0;
        if (!lock_sync) begin
          lose_lock = 1'b1;
          state_d   = S_WAIT_LOCK;
        end else if (req_valid && req_ready && (req_steps != '0) && (32'(req_chan) < N_OUT)) begin
          state_d = S_SETUP;
          rem_d   = req_steps;
        end
      end
      S_SETUP: begin
        if (!lock_sync) begin
          lose_lock = 1'b1;
          state_d   = S_WAIT_LOCK;
          rem_d     = '0;
        end else begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end
      end
      S_PULSE: begin
        if (!lock_sync) begin
          lose_lock = 1'b1;
          state_d   = S_WAIT_LOCK;
          cnt_d     = '0;
          rem_d     = '0;
        end else if (cnt_q == CNT_W'(STEP_LOW - 1)) begin
          state_d  = S_GAP;
          cnt_d    = '0;
          ofs_step = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (!lock_sync) begin
          lose_lock = 1'b1;
          state_d   = S_WAIT_LOCK;
          cnt_d     = '0;
          rem_d     = '0;
        end else if (cnt_q == CNT_W'(STEP_GAP - 1)) begin
          cnt_d   = '0;
          rem_d   = rem_q - STEP_W'(1);
          state_d = (rem_q == STEP_W'(1)) ? S_READY : S_PULSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the next state
  always_comb begin
    rst_d       = (state_d == S_RESET);
    ready_d     = state_d inside {S_READY, S_SETUP, S_PULSE, S_GAP};
    req_ready_d = (state_d == S_READY);
    busy_d      = state_d inside {S_SETUP, S_PULSE, S_GAP};
    step_d      = (state_d != S_PULSE);
    sel_d       = pll_phasesel;
    dir_d       = pll_phasedir;
    if ((state_q == S_READY) && (state_d == S_SETUP)) begin
      sel_d = req_chan;
      dir_d = req_dir;
    end
    relock_d = relock_count;
    if (lose_lock && (relock_count != 8'hFF)) relock_d = relock_count + 8'd1;
    for (int i = 0; i < N_OUT; i++) begin
      ofs_d[i] = ofs_q[i];
      if (state_d == S_RESET) begin
        ofs_d[i] = '0;
      end else if (ofs_step && (2'(i) == pll_phasesel)) begin
        ofs_d[i] = ofs_q[i] + (pll_phasedir ? PHASE_W'(1) : {PHASE_W{1'b1}});
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst       <= 1'b1;
      pll_phasesel  <= 2'd0;
      pll_phasedir  <= 1'b0;
      pll_phasestep <= 1'b1;
      ready         <= 1'b0;
      req_ready     <= 1'b0;
      busy          <= 1'b0;
      relock_count  <= 8'd0;
      for (int i = 0; i < N_OUT; i++) ofs_q[i] <= '0;
    end else begin
      pll_rst       <= rst_d;
      pll_phasesel  <= sel_d;
      pll_phasedir  <= dir_d;
      pll_phasestep <= step_d;
      ready         <= ready_d;
      req_ready     <= req_ready_d;
      busy          <= busy_d;
      relock_count  <= relock_d;
      for (int i = 0; i < N_OUT; i++) ofs_q[i] <= ofs_d[i];
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_ofs
    assign phase_ofs[g*PHASE_W +: PHASE_W] = ofs_q[g];
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: power-up, timeout re-reset, stepping, wrap,
// consumed requests, lock loss with relock, and asynchronous reset mid-sequence.
module tb_pll_phase_ctrl;

  localparam int unsigned N_OUT          = 3;
  localparam int unsigned RST_CYCLES     = 16;
  localparam int unsigned FILTER_CYCLES  = 64;
  localparam int unsigned TIMEOUT_CYCLES = 512;
  localparam int unsigned STEP_LOW       = 4;
  localparam int unsigned STEP_GAP       = 8;
  localparam int unsigned STEP_W         = 8;
  localparam int unsigned PHASE_W        = 6;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     pll_lock;
  logic                     pll_rst;
  logic [1:0]               pll_phasesel;
  logic                     pll_phasedir;
  logic                     pll_phasestep;
  logic                     ready;
  logic [7:0]               relock_count;
  logic                     req_valid;
  logic                     req_ready;
  logic [1:0]               req_chan;
  logic                     req_dir;
  logic [STEP_W-1:0]        req_steps;
  logic                     busy;
  logic [N_OUT*PHASE_W-1:0] phase_ofs;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  pll_phase_ctrl #(
    .N_OUT(N_OUT), .RST_CYCLES(RST_CYCLES), .FILTER_CYCLES(FILTER_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .STEP_LOW(STEP_LOW), .STEP_GAP(STEP_GAP),
    .STEP_W(STEP_W), .PHASE_W(PHASE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_rst(pll_rst),
    .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir),
    .pll_phasestep(pll_phasestep), .ready(ready), .relock_count(relock_count),
    .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan),
    .req_dir(req_dir), .req_steps(req_steps), .busy(busy), .phase_ofs(phase_ofs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst"},    32'(pll_rst), 32'd1);
    chk({tag, "_step"},   32'(pll_phasestep), 32'd1);
    chk({tag, "_sel"},    32'(pll_phasesel), 32'd0);
    chk({tag, "_dir"},    32'(pll_phasedir), 32'd0);
    chk({tag, "_ready"},  32'(ready), 32'd0);
    chk({tag, "_rready"}, 32'(req_ready), 32'd0);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_relock"}, 32'(relock_count), 32'd0);
    chk({tag, "_ofs"},    32'(phase_ofs), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    pll_lock  = 1'b0;
    req_valid = 1'b0;
    req_chan  = 2'd0;
    req_dir   = 1'b0;
    req_steps = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");

    // Release reset; pll_rst high for exactly 16 edges
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst_hold_15", 32'(pll_rst), 32'd1);
    @(negedge clk);
    chk("rst_fall_16", 32'(pll_rst), 32'd0);

    // No lock: re-reset after 512 WAIT_LOCK cycles, again 16 cycles wide
    repeat (511) @(negedge clk);
    chk("to_before", 32'(pll_rst), 32'd0);
    @(negedge clk);
    chk("to_rerst", 32'(pll_rst), 32'd1);
    chk("to_ready", 32'(ready), 32'd0);
    repeat (15) @(negedge clk);
    chk("to_hold", 32'(pll_rst), 32'd1);
    @(negedge clk);
    chk("to_fall", 32'(pll_rst), 32'd0);

    // Lock after 100 cycles; ready 2+64 edges later
    repeat (100) @(negedge clk);
    pll_lock = 1'b1;
    repeat (65) @(negedge clk);
    chk("lock_ready_early", 32'(ready), 32'd0);
    @(negedge clk);
    chk("lock_ready", 32'(ready), 32'd1);
    chk("lock_rready", 32'(req_ready), 32'd1);
    chk("lock_relock", 32'(relock_count), 32'd0);

    // chan=2, dir=+, 3 steps
    req_valid = 1'b1; req_chan = 2'd2; req_dir = 1'b1; req_steps = 8'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("s3_setup_rready", 32'(req_ready), 32'd0);
    chk("s3_setup_busy", 32'(busy), 32'd1);
    chk("s3_setup_sel", 32'(pll_phasesel), 32'd2);
    chk("s3_setup_dir", 32'(pll_phasedir), 32'd1);
    chk("s3_setup_step", 32'(pll_phasestep), 32'd1);
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      chk("s3_step", 32'(pll_phasestep), (k <= 36 && ((k - 1) % 12) < 4) ? 32'd0 : 32'd1);
      chk("s3_rready", 32'(req_ready), (k == 37) ? 32'd1 : 32'd0);
    end
    chk("s3_busy_done", 32'(busy), 32'd0);
    chk("s3_ofs", 32'(phase_ofs), 32'({6'd3, 6'd0, 6'd0}));

    // chan=0, dir=-, 1 step from 0 wraps to 63
    req_valid = 1'b1; req_chan = 2'd0; req_dir = 1'b0; req_steps = 8'd1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (13) @(negedge clk);
    chk("wrap_rready", 32'(req_ready), 32'd1);
    chk("wrap_busy", 32'(busy), 32'd0);
    chk("wrap_dir", 32'(pll_phasedir), 32'd0);
    chk("wrap_ofs", 32'(phase_ofs), 32'({6'd3, 6'd0, 6'd63}));

    // Zero-step then out-of-range channel, back to back
    req_valid = 1'b1; req_chan = 2'd1; req_dir = 1'b1; req_steps = 8'd0;
    @(negedge clk);
    chk("zero_rready", 32'(req_ready), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_step", 32'(pll_phasestep), 32'd1);
    chk("zero_sel", 32'(pll_phasesel), 32'd0);
    req_chan = 2'd3; req_steps = 8'd5;
    @(negedge clk);
    req_valid = 1'b0;
    chk("oor_rready", 32'(req_ready), 32'd1);
    chk("oor_busy", 32'(busy), 32'd0);
    chk("oor_step", 32'(pll_phasestep), 32'd1);
    chk("oor_ofs", 32'(phase_ofs), 32'({6'd3, 6'd0, 6'd63}));

    // Lock loss in the second PULSE of a 5-step request
    req_valid = 1'b1; req_chan = 2'd1; req_dir = 1'b1; req_steps = 8'd5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (13) @(negedge clk);
    chk("ll_in_pulse", 32'(pll_phasestep), 32'd0);
    chk("ll_ofs_one", 32'(phase_ofs), 32'({6'd3, 6'd1, 6'd63}));
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    chk("ll_still_low", 32'(pll_phasestep), 32'd0);
    chk("ll_still_ready", 32'(ready), 32'd1);
    @(negedge clk);
    chk("ll_step_high", 32'(pll_phasestep), 32'd1);
    chk("ll_ready", 32'(ready), 32'd0);
    chk("ll_rready", 32'(req_ready), 32'd0);
    chk("ll_busy", 32'(busy), 32'd0);
    chk("ll_relock", 32'(relock_count), 32'd1);
    chk("ll_ofs_kept", 32'(phase_ofs), 32'({6'd3, 6'd1, 6'd63}));

    // Relock
    pll_lock = 1'b1;
    repeat (65) @(negedge clk);
    chk("re_ready_early", 32'(ready), 32'd0);
    chk("re_step_idle", 32'(pll_phasestep), 32'd1);
    @(negedge clk);
    chk("re_ready", 32'(ready), 32'd1);
    chk("re_relock", 32'(relock_count), 32'd1);
    chk("re_ofs", 32'(phase_ofs), 32'({6'd3, 6'd1, 6'd63}));

    // Asynchronous reset in GAP
    req_valid = 1'b1; req_chan = 2'd0; req_dir = 1'b1; req_steps = 8'd2;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_step", 32'(pll_phasestep), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
